// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch key front-end.
// Default timing assumes the 125 MHz system clock.
package stopwatch_pkg;

  localparam int CLK_HZ          = 125_000_000;
  localparam int DB_CYCLES_DEF   = CLK_HZ / 50;  // 20 ms
  localparam int LONG_CYCLES_DEF = CLK_HZ;       // 1 s

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } key_state_t;

  // Counter width for a terminal count of n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus counter debouncer for one raw button.
// KEY_DB follows a stable KEY_IN change exactly 2+DB_CYCLES cycles later.
module key_debounce
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic KEY_IN,
  output logic KEY_DB
);

  localparam int              CW       = cnt_w(DB_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);

  logic          r_sync1;
  logic          r_key_s;
  logic          r_key_db;
  logic [CW-1:0] r_cnt;

  // Any disagreement between the synchronized and accepted levels must last
  // DB_CYCLES consecutive cycles; a single agreeing cycle restarts the count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1  <= 1'b0;
      r_key_s  <= 1'b0;
      r_key_db <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= KEY_IN;
      r_key_s <= r_sync1;
      if (r_key_s == r_key_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_key_db <= r_key_s;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign KEY_DB = r_key_db;

endmodule

// File: rtl/key_ctrl.sv
// Push-button front-end: debounced press tracking and stopwatch run/stop level.
// Optional long-press clear is compiled in with KEY_LONGPRESS_CLR_EN.
module key_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int LONG_CYCLES = LONG_CYCLES_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic KEY,
  output logic STR_STP,
  output logic PRESS_PULSE,
  output logic CLR
);

  if (DB_CYCLES < 2 || LONG_CYCLES <= DB_CYCLES) begin : g_bad_params
    $error("key_ctrl: need DB_CYCLES >= 2 and LONG_CYCLES > DB_CYCLES");
  end

  logic       w_key_db;
  logic       w_rise;
  logic       w_fall;
  logic       w_toggle;
  logic       r_key_db_d;
  logic       r_press_pulse;
  logic       r_str_stp;
  logic       r_clr;
  key_state_t r_state;

  key_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_debounce (
    .CLK    (CLK),
    .RST    (RST),
    .KEY_IN (KEY),
    .KEY_DB (w_key_db)
  );

  assign w_rise =  w_key_db & ~r_key_db_d;
  assign w_fall = ~w_key_db &  r_key_db_d;

`ifdef KEY_LONGPRESS_CLR_EN
  localparam int            LW        = cnt_w(LONG_CYCLES);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

  logic [LW-1:0] r_long_cnt;
  logic          r_rel_toggle;

  // Toggle waits for the release so a long-press can cancel it.
  assign w_toggle = r_rel_toggle;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state       <= IDLE;
      r_key_db_d    <= 1'b0;
      r_press_pulse <= 1'b0;
      r_rel_toggle  <= 1'b0;
      r_str_stp     <= 1'b0;
      r_clr         <= 1'b0;
      r_long_cnt    <= '0;
    end else begin
      r_key_db_d    <= w_key_db;
      r_press_pulse <= 1'b0;
      r_rel_toggle  <= 1'b0;
      r_clr         <= 1'b0;
      if (w_toggle) begin
        r_str_stp <= ~r_str_stp;
      end
      case (r_state)
        IDLE: begin
          r_long_cnt <= '0;
          if (w_rise) begin
            r_state       <= PRESSED;
            r_press_pulse <= 1'b1;
          end
        end
        PRESSED: begin
          if (w_fall) begin
            r_state      <= IDLE;
            r_rel_toggle <= 1'b1;
            r_long_cnt   <= '0;
          end else if (r_long_cnt == LONG_LAST) begin
            r_state    <= HELD;
            r_clr      <= 1'b1;
            r_str_stp  <= 1'b0;
            r_long_cnt <= '0;
          end else begin
            r_long_cnt <= r_long_cnt + LW'(1);
          end
        end
        HELD: begin
          if (w_fall) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`else
  // Each accepted press flips the run level one cycle after its strobe.
  assign w_toggle = r_press_pulse;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state       <= IDLE;
      r_key_db_d    <= 1'b0;
      r_press_pulse <= 1'b0;
      r_str_stp     <= 1'b0;
      r_clr         <= 1'b0;
    end else begin
      r_key_db_d    <= w_key_db;
      r_press_pulse <= 1'b0;
      r_clr         <= 1'b0;
      if (w_toggle) begin
        r_str_stp <= ~r_str_stp;
      end
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state       <= PRESSED;
            r_press_pulse <= 1'b1;
          end
        end
        PRESSED, HELD: begin
          if (w_fall) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`endif

  assign STR_STP     = r_str_stp;
  assign PRESS_PULSE = r_press_pulse;
  assign CLR         = r_clr;

endmodule

// File: tb/tb_key_ctrl.sv
// Directed bench for key_ctrl with DB_CYCLES=4, LONG_CYCLES=20.
module tb_key_ctrl;

`ifdef KEY_LONGPRESS_CLR_EN
  localparam bit LP = 1'b1;
`else
  localparam bit LP = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST;
  logic KEY;
  logic STR_STP;
  logic PRESS_PULSE;
  logic CLR;

  int checks   = 0;
  int failures = 0;
  int n_press  = 0;
  int n_clr    = 0;

  key_ctrl #(
    .DB_CYCLES   (4),
    .LONG_CYCLES (20)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .KEY         (KEY),
    .STR_STP     (STR_STP),
    .PRESS_PULSE (PRESS_PULSE),
    .CLR         (CLR)
  );

  always #4 CLK = ~CLK;

  always @(posedge CLK) begin
    #1;
    if (PRESS_PULSE === 1'b1) n_press++;
    if (CLR === 1'b1) n_clr++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    KEY = v;
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_press(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge CLK);
      #1;
      if (PRESS_PULSE === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  int seq_exp [3] = '{0, 1, 0};
  bit seen;

  initial begin
    RST = 1'b1;
    KEY = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_str", STR_STP, 0);
    chk("rst_pp", PRESS_PULSE, 0);
    chk("rst_clr", CLR, 0);

    // Key held across reset release: strobe on the 7th edge, toggle on the 8th.
    RST = 1'b0;
    repeat (6) @(posedge CLK);
    #1 chk("pp_before_7", PRESS_PULSE, 0);
    @(posedge CLK);
    #1 chk("pp_at_7", PRESS_PULSE, 1);
    chk("str_at_7", STR_STP, 0);
    @(posedge CLK);
    #1 chk("pp_one_cycle", PRESS_PULSE, 0);
    chk("str_at_8", STR_STP, LP ? 0 : 1);
    @(negedge CLK);
    drive(1'b0, 12);
    chk("str_after_release", STR_STP, 1);

    n_press = 0;
    drive(1'b1, 3);
    drive(1'b0, 15);
    chk("glitch3_pulses", n_press, 0);
    chk("glitch3_str", STR_STP, 1);

    n_press = 0;
    drive(1'b1, 4);
    drive(1'b0, 15);
    chk("min4_pulses", n_press, 1);
    chk("min4_str", STR_STP, 0);

    n_press = 0;
    drive(1'b1, 10);
    drive(1'b0, 15);
    chk("press10_pulses", n_press, 1);
    chk("press10_str", STR_STP, 1);

    n_press = 0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 12; j++) drive((j % 2) == 0, 1);
      drive(1'b1, 10);
      drive(1'b0, 10);
      chk($sformatf("seq_str_%0d", i), STR_STP, seq_exp[i]);
    end
    chk("seq_pulses", n_press, 3);

`ifndef KEY_LONGPRESS_CLR_EN
    n_press = 0;
    n_clr   = 0;
    drive(1'b1, 100);
    chk("hold_str_mid", STR_STP, 1);
    drive(1'b0, 15);
    chk("hold_pulses", n_press, 1);
    chk("hold_clr", n_clr, 0);
    chk("hold_str", STR_STP, 1);
`else
    n_clr = 0;
    drive(1'b1, 10);
    chk("short_str_held", STR_STP, 0);
    drive(1'b0, 15);
    chk("short_str_rel", STR_STP, 1);
    chk("short_clr", n_clr, 0);

    n_clr = 0;
    KEY = 1'b1;
    wait_press(seen);
    chk("long_pp_seen", seen, 1);
    repeat (19) @(posedge CLK);
    #1 chk("long_clr_early", CLR, 0);
    chk("long_str_early", STR_STP, 1);
    @(posedge CLK);
    #1 chk("long_clr_at20", CLR, 1);
    chk("long_str_forced", STR_STP, 0);
    @(posedge CLK);
    #1 chk("long_clr_one_cycle", CLR, 0);
    @(negedge CLK);
    drive(1'b1, 12);
    drive(1'b0, 15);
    chk("long_str_after_rel", STR_STP, 0);
    chk("long_clr_count", n_clr, 1);
`endif

    // Reset in the strobe cycle of a press, then re-accept the held key.
    drive(1'b1, 7);
    RST = 1'b1;
    #1;
    chk("midrst_pp", PRESS_PULSE, 0);
    chk("midrst_str", STR_STP, 0);
    chk("midrst_clr", CLR, 0);
    @(negedge CLK);
    RST = 1'b0;
    wait_press(seen);
    chk("repress_seen", seen, 1);
    @(posedge CLK);
    #1 chk("repress_str", STR_STP, LP ? 0 : 1);
    @(negedge CLK);
    drive(1'b0, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
